mem_port_arbiter: RTL

Sequencer and arbiter that shares one single-ported memory between the instruction-fetch, load and store requesters of the multicycle CPU. Replaces separate instruction and data ports with one request/ready memory interface that supports wait states. Sits between the CPU's fetch/MEM stage outputs and the memory controller. It grants one requester at a time, holds the transaction until memory answers, and returns a one-cycle completion pulse plus registered read data. A watchdog aborts transactions that memory never answers.

---
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported request/ready memory between fetch, load and store requesters, with a wait-state watchdog.
// Fixed priority st > ld > if by default; define ARB_ROUND_ROBIN_EN for round-robin grant order.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int W       = `WORD_WIDTH,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_if_req,
  input  logic         i_ld_req,
  input  logic         i_st_req,
  input  logic [W-1:0] i_if_addr,
  input  logic [W-1:0] i_ld_addr,
  input  logic [W-1:0] i_st_addr,
  input  logic [W-1:0] i_st_data,
  output logic         o_if_done,
  output logic         o_ld_done,
  output logic         o_st_done,
  output logic [W-1:0] o_if_rdata,
  output logic [W-1:0] o_ld_rdata,
  output logic         o_mem_req,
  output logic         o_mem_we,
  output logic [W-1:0] o_mem_addr,
  output logic [W-1:0] o_mem_wdata,
  input  logic [W-1:0] i_mem_rdata,
  input  logic         i_mem_ready,
  output logic         o_err,
  output logic         o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  localparam logic [1:0] ID_ST = 2'd0;
  localparam logic [1:0] ID_LD = 2'd1;
  localparam logic [1:0] ID_IF = 2'd2;

  state_t          r_state, w_nxt_state;
  logic [1:0]      r_id, w_gnt_id;
  logic            w_gnt_vld, w_ready_hit, w_timeout;
  logic [TO_W-1:0] r_cnt;
  logic [2:0]      w_req_vec;
  logic            r_if_done, r_ld_done, r_st_done, r_err, r_busy, r_mem_req, r_mem_we;
  logic [W-1:0]    r_if_rdata, r_ld_rdata, r_mem_addr, r_mem_wdata;

  assign w_req_vec = {i_if_req, i_ld_req, i_st_req};

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] r_ptr, w_c0, w_c1, w_c2;

  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id == ID_IF) ? ID_ST : id + 2'd1;
  endfunction

  // Search order starts at the pointer: st -> ld -> if -> st.
  always_comb begin
    w_c0      = r_ptr;
    w_c1      = next_id(w_c0);
    w_c2      = next_id(w_c1);
    w_gnt_vld = 1'b1;
    w_gnt_id  = w_c0;
    if (w_req_vec[w_c0])      w_gnt_id = w_c0;
    else if (w_req_vec[w_c1]) w_gnt_id = w_c1;
    else if (w_req_vec[w_c2]) w_gnt_id = w_c2;
    else                      w_gnt_vld = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                              r_ptr <= ID_ST;
    else if (r_state == S_IDLE && w_gnt_vld) r_ptr <= next_id(w_gnt_id);
  end
`else
  always_comb begin
    w_gnt_vld = |w_req_vec;
    w_gnt_id  = ID_ST;
    if (i_st_req)      w_gnt_id = ID_ST;
    else if (i_ld_req) w_gnt_id = ID_LD;
    else if (i_if_req) w_gnt_id = ID_IF;
  end
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_ready_hit = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: if (w_gnt_vld) w_nxt_state = S_BUSY;
      S_BUSY: begin
        w_ready_hit = i_mem_ready;
        // ready on the last allowed wait cycle still wins over the abort
        w_timeout   = !i_mem_ready && (r_cnt == TO_W'(TIMEOUT - 1));
        if (w_ready_hit || w_timeout) w_nxt_state = S_DONE;
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nxt_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_id        <= ID_ST;
      r_cnt       <= '0;
      r_if_done   <= 1'b0;
      r_ld_done   <= 1'b0;
      r_st_done   <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_ld_rdata  <= '0;
    end else begin
      r_if_done <= 1'b0;
      r_ld_done <= 1'b0;
      r_st_done <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= (w_nxt_state != S_IDLE);
      r_mem_req <= (w_nxt_state == S_BUSY);
      if (r_state == S_IDLE && w_gnt_vld) begin
        r_id        <= w_gnt_id;
        r_cnt       <= '0;
        r_mem_we    <= (w_gnt_id == ID_ST);
        r_mem_wdata <= (w_gnt_id == ID_ST) ? i_st_data : '0;
        case (w_gnt_id)
          ID_ST:   r_mem_addr <= i_st_addr;
          ID_LD:   r_mem_addr <= i_ld_addr;
          default: r_mem_addr <= i_if_addr;
        endcase
      end
      if (r_state == S_BUSY) begin
        if (w_ready_hit || w_timeout) begin
          r_err <= w_timeout;
          case (r_id)
            ID_ST: r_st_done <= 1'b1;
            ID_LD: begin
              r_ld_done  <= 1'b1;
              r_ld_rdata <= w_ready_hit ? i_mem_rdata : '0;
            end
            default: begin
              r_if_done  <= 1'b1;
              r_if_rdata <= w_ready_hit ? i_mem_rdata : '0;
            end
          endcase
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_if_done   = r_if_done;
  assign o_ld_done   = r_ld_done;
  assign o_st_done   = r_st_done;
  assign o_if_rdata  = r_if_rdata;
  assign o_ld_rdata  = r_ld_rdata;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_err       = r_err;
  assign o_busy      = r_busy;

endmodule
